// File: rtl/sram_copy_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sram_copy_sequencer
// Purpose  : Wishbone-configured block copier for the shared SRAM datapath.
//            Issues one read per cycle and writes each returned word to the
//            destination region once the fixed read latency has elapsed.
// Revision : 1.0 - initial release
// ============================================================================
module sram_copy_sequencer #(
  parameter int MEM_ADDR_BITS = 10,
  parameter int MEM_DATA_BITS = 512,
  parameter int RD_LATENCY    = 2,
  parameter int WB_ADR_BITS   = 8,
  parameter int WB_DAT_BITS   = 64
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [WB_ADR_BITS-1:0]   s_wb_adr_i,
  input  logic [WB_DAT_BITS-1:0]   s_wb_dat_i,
  output logic [WB_DAT_BITS-1:0]   s_wb_dat_o,
  input  logic                     s_wb_we_i,
  input  logic [WB_DAT_BITS/8-1:0] s_wb_sel_i,
  input  logic                     s_wb_stb_i,
  output logic                     s_wb_ack_o,
  output logic                     m_rd_en,
  output logic [MEM_ADDR_BITS-1:0] m_rd_addr,
  input  logic [MEM_DATA_BITS-1:0] m_rd_data,
  output logic                     m_wr_en,
  output logic [MEM_ADDR_BITS-1:0] m_wr_addr,
  output logic [MEM_DATA_BITS-1:0] m_wr_data,
  output logic                     irq
);

  localparam int AW = MEM_ADDR_BITS;
  localparam int LW = MEM_ADDR_BITS + 1;
  localparam logic [31:0] ID_VALUE = 32'h5352_4350;

  localparam logic [WB_ADR_BITS-1:0] REG_ID     = WB_ADR_BITS'(0);
  localparam logic [WB_ADR_BITS-1:0] REG_CTRL   = WB_ADR_BITS'(1);
  localparam logic [WB_ADR_BITS-1:0] REG_STATUS = WB_ADR_BITS'(2);
  localparam logic [WB_ADR_BITS-1:0] REG_SRC    = WB_ADR_BITS'(3);
  localparam logic [WB_ADR_BITS-1:0] REG_DST    = WB_ADR_BITS'(4);
  localparam logic [WB_ADR_BITS-1:0] REG_LEN    = WB_ADR_BITS'(5);
  localparam logic [WB_ADR_BITS-1:0] REG_COUNT  = WB_ADR_BITS'(6);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic [AW-1:0]          src, dst, rd_ptr, wr_ptr;
  logic [LW-1:0]          len, count, issue_left;
  logic                   done, ack;
  logic [WB_DAT_BITS-1:0] dat_o, rdata, wmask;
  logic [RD_LATENCY-1:0]  vld, vld_shift, vld_nx;

  logic acc, wr_acc, busy, issue, wr_fire;
  logic start_req, abort_req, clr_done;
  logic do_launch, do_empty, do_finish, do_abort;
  logic unused_bits;

  // Expand byte selects into a bit mask so partial writes merge cleanly.
  for (genvar i = 0; i < WB_DAT_BITS/8; i++) begin : g_wmask
    assign wmask[8*i +: 8] = {8{s_wb_sel_i[i]}};
  end

  assign unused_bits = ^{s_wb_dat_i[WB_DAT_BITS-1:LW], wmask[WB_DAT_BITS-1:LW]};

  assign acc       = s_wb_stb_i & ~ack;
  assign wr_acc    = acc & s_wb_we_i;
  assign start_req = wr_acc & (s_wb_adr_i == REG_CTRL)   & s_wb_sel_i[0] & s_wb_dat_i[0];
  assign abort_req = wr_acc & (s_wb_adr_i == REG_CTRL)   & s_wb_sel_i[0] & s_wb_dat_i[1];
  assign clr_done  = wr_acc & (s_wb_adr_i == REG_STATUS) & s_wb_sel_i[0] & s_wb_dat_i[1];

  assign busy    = (state != S_IDLE);
  assign issue   = (state == S_RUN);
  assign wr_fire = vld[RD_LATENCY-1];
  // Stages other than the exit stage; nonzero means more writes are coming.
  assign vld_shift = vld << 1;

  assign m_rd_en    = issue;
  assign m_rd_addr  = rd_ptr;
  assign m_wr_en    = wr_fire;
  assign m_wr_addr  = wr_ptr;
  assign m_wr_data  = wr_fire ? m_rd_data : '0;
  assign s_wb_ack_o = ack;
  assign s_wb_dat_o = dat_o;
  assign irq        = done;

  // Register read multiplexer; unmapped addresses return zero.
  always_comb begin
    rdata = '0;
    case (s_wb_adr_i)
      REG_ID:     rdata[31:0]   = ID_VALUE;
      REG_STATUS: rdata[1:0]    = {done, busy};
      REG_SRC:    rdata[AW-1:0] = src;
      REG_DST:    rdata[AW-1:0] = dst;
      REG_LEN:    rdata[LW-1:0] = len;
      REG_COUNT:  rdata[LW-1:0] = count;
      default:    rdata         = '0;
    endcase
  end

  // Next-state logic; abort outranks start and any pending completion.
  always_comb begin
    state_nx  = state;
    do_launch = 1'b0;
    do_empty  = 1'b0;
    do_finish = 1'b0;
    do_abort  = 1'b0;
    vld_nx    = vld_shift;
    vld_nx[0] = issue;
    case (state)
      S_IDLE: begin
        if (start_req && !abort_req) begin
          if (len == '0) begin
            do_empty = 1'b1;
          end else begin
            do_launch = 1'b1;
            state_nx  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort_req) begin
          do_abort = 1'b1;
          state_nx = S_IDLE;
        end else if (issue_left == LW'(1)) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_req) begin
          do_abort = 1'b1;
          state_nx = S_IDLE;
        end else if (wr_fire && (vld_shift == '0)) begin
          do_finish = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (do_abort) vld_nx = '0;
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Wishbone handshake, configuration registers, pointers and write pipeline.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ack        <= 1'b0;
      dat_o      <= '0;
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      count      <= '0;
      done       <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      issue_left <= '0;
      vld        <= '0;
    end else begin
      ack   <= acc;
      dat_o <= acc ? rdata : '0;
      vld   <= vld_nx;

      if (wr_acc && !busy) begin
        case (s_wb_adr_i)
          REG_SRC: src <= (src & ~wmask[AW-1:0]) | (s_wb_dat_i[AW-1:0] & wmask[AW-1:0]);
          REG_DST: dst <= (dst & ~wmask[AW-1:0]) | (s_wb_dat_i[AW-1:0] & wmask[AW-1:0]);
          REG_LEN: len <= (len & ~wmask[LW-1:0]) | (s_wb_dat_i[LW-1:0] & wmask[LW-1:0]);
          default: ;
        endcase
      end

      if (do_launch) begin
        rd_ptr     <= src;
        wr_ptr     <= dst;
        issue_left <= len;
      end else begin
        if (issue) begin
          rd_ptr     <= rd_ptr + AW'(1);
          issue_left <= issue_left - LW'(1);
        end
        if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      end

      if (do_launch || do_empty) count <= '0;
      else if (wr_fire)          count <= count + LW'(1);

      if (do_launch)                           done <= 1'b0;
      else if (do_empty || do_finish || do_abort) done <= 1'b1;
      else if (clr_done)                       done <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_copy_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_copy_sequencer
// Purpose  : Directed self-checking bench for sram_copy_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_copy_sequencer;

  localparam logic [7:0] A_ID = 8'd0, A_CTRL = 8'd1, A_STATUS = 8'd2, A_SRC = 8'd3;
  localparam logic [7:0] A_DST = 8'd4, A_LEN = 8'd5, A_COUNT = 8'd6;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [7:0]   adr = '0;
  logic [63:0]  dat_i = '0;
  logic [63:0]  dat_o;
  logic         we = 1'b0;
  logic [7:0]   sel = '0;
  logic         stb = 1'b0;
  logic         ack;
  logic         rd_en, wr_en, irq;
  logic [9:0]   rd_addr, wr_addr;
  logic [511:0] rd_data, wr_data;
  logic [511:0] d1 = '0, d2 = '0;

  typedef struct {
    int           cyc;
    logic [9:0]   addr;
    logic [511:0] data;
  } ev_t;

  ev_t rdq[$];
  ev_t wrq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  last_ack_cyc = 0;

  sram_copy_sequencer #(
    .MEM_ADDR_BITS(10), .MEM_DATA_BITS(512), .RD_LATENCY(2),
    .WB_ADR_BITS(8), .WB_DAT_BITS(64)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_wb_adr_i(adr), .s_wb_dat_i(dat_i), .s_wb_dat_o(dat_o),
    .s_wb_we_i(we), .s_wb_sel_i(sel), .s_wb_stb_i(stb), .s_wb_ack_o(ack),
    .m_rd_en(rd_en), .m_rd_addr(rd_addr), .m_rd_data(rd_data),
    .m_wr_en(wr_en), .m_wr_addr(wr_addr), .m_wr_data(wr_data),
    .irq(irq)
  );

  always #5 aclk = ~aclk;

  // Distinct data word per SRAM address.
  function automatic logic [511:0] mdata(input logic [9:0] a);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = 32'hDA7A_0000 ^ (32'(a) << 4) ^ 32'(i);
    return d;
  endfunction

  // SRAM model with two-cycle read latency.
  always @(posedge aclk) begin
    d1 <= rd_en ? mdata(rd_addr) : '0;
    d2 <= d1;
    cyc <= cyc + 1;
  end
  assign rd_data = d2;

  // Log memory traffic at mid-cycle.
  always @(negedge aclk) begin
    if (rd_en) rdq.push_back('{cyc, rd_addr, '0});
    if (wr_en) wrq.push_back('{cyc, wr_addr, wr_data});
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wb(input logic [7:0] a, input logic [63:0] d, input logic w,
                    input logic [7:0] s, output logic [63:0] q);
    int n;
    n = 0;
    @(negedge aclk);
    adr = a; dat_i = d; we = w; sel = s; stb = 1'b1;
    do begin
      @(negedge aclk);
      n++;
    end while (!ack && n < 20);
    check("wb_ack", 512'(ack), 512'(1));
    q = dat_o;
    last_ack_cyc = cyc;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d);
    logic [63:0] q;
    wb(a, d, 1'b1, 8'hFF, q);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [63:0] exp);
    logic [63:0] q;
    wb(a, 64'd0, 1'b0, 8'hFF, q);
    check(tag, 512'(q), 512'(exp));
  endtask

  task automatic wait_to(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 1000) begin
      @(negedge aclk);
      n++;
    end
  endtask

  task automatic start_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] l,
                            output int e0);
    wr(A_SRC, 64'(s));
    wr(A_DST, 64'(d));
    wr(A_LEN, 64'(l));
    rdq.delete();
    wrq.delete();
    wr(A_CTRL, 64'h1);
    e0 = last_ack_cyc;
  endtask

  initial begin
    int e0, a, n;
    logic [63:0] q;

    // Reset values
    repeat (2) @(negedge aclk);
    check("rst_ack", 512'(ack), 512'(0));
    check("rst_dat_o", 512'(dat_o), 512'(0));
    check("rst_rd_en", 512'(rd_en), 512'(0));
    check("rst_rd_addr", 512'(rd_addr), 512'(0));
    check("rst_wr_en", 512'(wr_en), 512'(0));
    check("rst_wr_addr", 512'(wr_addr), 512'(0));
    check("rst_wr_data", wr_data, 512'(0));
    check("rst_irq", 512'(irq), 512'(0));
    aresetn = 1'b1;
    rd_chk("id", A_ID, 64'h5352_4350);
    rd_chk("status_rst", A_STATUS, 64'h0);
    rd_chk("unmapped", 8'd9, 64'h0);

    // Basic 4-word copy with exact timing
    start_copy(10'h010, 10'h200, 11'd4, e0);
    wait_to(e0 + 5);
    check("basic_irq_before", 512'(irq), 512'(0));
    wait_to(e0 + 6);
    check("basic_irq_after", 512'(irq), 512'(1));
    check("basic_nrd", 512'(rdq.size()), 512'(4));
    check("basic_nwr", 512'(wrq.size()), 512'(4));
    for (int k = 0; k < 4 && k < rdq.size() && k < wrq.size(); k++) begin
      check("basic_rd_addr", 512'(rdq[k].addr), 512'(10'h010 + k));
      check("basic_rd_cyc", 512'(rdq[k].cyc), 512'(e0 + k));
      check("basic_wr_addr", 512'(wrq[k].addr), 512'(10'h200 + k));
      check("basic_wr_cyc", 512'(wrq[k].cyc), 512'(e0 + k + 2));
      check("basic_wr_data", wrq[k].data, mdata(10'(10'h010 + k)));
    end
    rd_chk("basic_status", A_STATUS, 64'h2);
    rd_chk("basic_count", A_COUNT, 64'd4);

    // W1C done, then zero-length start
    wr(A_STATUS, 64'h2);
    check("w1c_irq", 512'(irq), 512'(0));
    start_copy(10'h005, 10'h006, 11'd0, e0);
    check("len0_irq", 512'(irq), 512'(1));
    repeat (5) @(negedge aclk);
    check("len0_nrd", 512'(rdq.size()), 512'(0));
    check("len0_nwr", 512'(wrq.size()), 512'(0));
    rd_chk("len0_count", A_COUNT, 64'd0);

    // Byte-select partial write: only byte 1 of SRC updates
    wr(A_SRC, 64'h050);
    wb(A_SRC, 64'h3FF, 1'b1, 8'h02, q);
    rd_chk("sel_src", A_SRC, 64'h350);

    // Address wrap
    start_copy(10'h3FE, 10'h3FF, 11'd3, e0);
    wait_to(e0 + 8);
    check("wrap_nwr", 512'(wrq.size()), 512'(3));
    for (int k = 0; k < 3 && k < rdq.size() && k < wrq.size(); k++) begin
      check("wrap_rd_addr", 512'(rdq[k].addr), 512'(10'(10'h3FE + k)));
      check("wrap_wr_addr", 512'(wrq[k].addr), 512'(10'(10'h3FF + k)));
    end

    // Abort a long copy mid-flight
    start_copy(10'h000, 10'h100, 11'd100, e0);
    wait_to(e0 + 9);
    wr(A_CTRL, 64'h2);
    a = last_ack_cyc;
    check("abort_irq", 512'(irq), 512'(1));
    check("abort_rd_en", 512'(rd_en), 512'(0));
    check("abort_nrd", 512'(rdq.size()), 512'(a - e0));
    check("abort_nwr", 512'(wrq.size()), 512'(a - e0 - 2));
    repeat (6) @(negedge aclk);
    check("abort_nrd_after", 512'(rdq.size()), 512'(a - e0));
    check("abort_nwr_after", 512'(wrq.size()), 512'(a - e0 - 2));
    rd_chk("abort_status", A_STATUS, 64'h2);
    rd_chk("abort_count", A_COUNT, 64'(a - e0 - 2));
    start_copy(10'h020, 10'h040, 11'd2, e0);
    wait_to(e0 + 6);
    check("post_abort_nwr", 512'(wrq.size()), 512'(2));
    if (wrq.size() == 2) check("post_abort_wr1", 512'(wrq[1].addr), 512'(10'h041));
    rd_chk("post_abort_count", A_COUNT, 64'd2);

    // Writes and start while busy are ignored
    start_copy(10'h050, 10'h060, 11'd12, e0);
    rd_chk("busy_status", A_STATUS, 64'h1);
    wr(A_SRC, 64'h077);
    wr(A_LEN, 64'd3);
    wr(A_CTRL, 64'h1);
    rd_chk("busy_src", A_SRC, 64'h050);
    rd_chk("busy_len", A_LEN, 64'd12);
    wait_to(e0 + 20);
    check("busy_nwr", 512'(wrq.size()), 512'(12));
    if (wrq.size() == 12) check("busy_last_wr", 512'(wrq[11].addr), 512'(10'h06B));
    rd_chk("busy_count", A_COUNT, 64'd12);
    wr(A_STATUS, 64'h2);
    check("clr_irq", 512'(irq), 512'(0));
    rd_chk("clr_status", A_STATUS, 64'h0);

    // Reset mid-copy
    start_copy(10'h100, 10'h300, 11'd16, e0);
    wait_to(e0 + 4);
    check("mid_rd_en", 512'(rd_en), 512'(1));
    aresetn = 1'b0;
    #1;
    n = wrq.size();
    check("mid_rst_rd_en", 512'(rd_en), 512'(0));
    check("mid_rst_rd_addr", 512'(rd_addr), 512'(0));
    check("mid_rst_wr_en", 512'(wr_en), 512'(0));
    check("mid_rst_wr_addr", 512'(wr_addr), 512'(0));
    check("mid_rst_wr_data", wr_data, 512'(0));
    check("mid_rst_irq", 512'(irq), 512'(0));
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (8) @(negedge aclk);
    check("mid_rst_no_wr", 512'(wrq.size()), 512'(n));
    rd_chk("mid_rst_id", A_ID, 64'h5352_4350);
    rd_chk("mid_rst_status", A_STATUS, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
